// File: rtl/sram_pkg.sv
// Shared types and default parameters for the SRAM responder slice.
//   state_t       : responder FSM states
//   DEF_*         : default WIDTH / DEPTH / WAIT_CYCLES
//   CNT_W         : wait-state counter width (covers WAIT_CYCLES 0..15)
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH       = 16;
  localparam int unsigned DEF_DEPTH       = 64;
  localparam int unsigned DEF_WAIT_CYCLES = 2;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/sram_responder_if.sv
// Single-port valid/ready memory request interface.
//   valid_i/wr_rd_i/addr_i/wdata_i : request from initiator
//   ready_o/rdata_o/err_o          : one-cycle completion from responder
interface sram_responder_if #(
  parameter int unsigned WIDTH     = sram_pkg::DEF_WIDTH,
  parameter int unsigned ADDR_SIZE = $clog2(sram_pkg::DEF_DEPTH)
);

  logic                 valid_i;
  logic                 wr_rd_i;
  logic [ADDR_SIZE-1:0] addr_i;
  logic [WIDTH-1:0]     wdata_i;
  logic                 ready_o;
  logic [WIDTH-1:0]     rdata_o;
  logic                 err_o;

  modport master (
    output valid_i, wr_rd_i, addr_i, wdata_i,
    input  ready_o, rdata_o, err_o
  );

  modport slave (
    input  valid_i, wr_rd_i, addr_i, wdata_i,
    output ready_o, rdata_o, err_o
  );

endinterface

// File: rtl/sram_array.sv
// WIDTH x DEPTH storage: synchronous write, registered read, async clear.
//   clk, rst_n     : clock, async active-low clear of all words and rdata
//   we/addr/wdata  : write port (caller guarantees addr < DEPTH when we=1)
//   re/rd_zero     : load rdata with mem[addr], or with 0 when rd_zero=1
//   rdata          : registered read data, holds between reads
module sram_array #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_SIZE = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic                 re,
  input  logic                 rd_zero,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage and read register share one clear so reset wipes everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= rd_zero ? '0 : mem[addr];
    end
  end

endmodule

// File: rtl/sram_responder.sv
// Responder end of the valid/ready memory interface with programmable wait states.
//   clk_i : clock
//   rst_i : async active-low reset (aborts any request, clears the array)
//   bus   : slave modport of sram_responder_if
module sram_responder
  import sram_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned ADDR_SIZE   = $clog2(DEPTH),
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  sram_responder_if.slave  bus
);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [ADDR_SIZE-1:0] addr_q;
  logic                 wr_q;
  logic [WIDTH-1:0]     wdata_q;
  logic                 ready_q;
  logic                 err_q;
  logic [WIDTH-1:0]     rdata;

  logic                 go_resp_c;
  logic [ADDR_SIZE-1:0] acc_addr_c;
  logic                 acc_wr_c;
  logic [WIDTH-1:0]     acc_wdata_c;
  logic                 in_range_c;

  // The access happens on the edge that enters RESP; with zero wait states
  // that is the capture edge itself, so the live inputs are used in IDLE.
  always_comb begin
    acc_addr_c  = addr_q;
    acc_wr_c    = wr_q;
    acc_wdata_c = wdata_q;
    go_resp_c   = 1'b0;
    if (state == IDLE) begin
      acc_addr_c  = bus.addr_i;
      acc_wr_c    = bus.wr_rd_i;
      acc_wdata_c = bus.wdata_i;
      go_resp_c   = bus.valid_i && (WAIT_CYCLES == 0);
    end else if (state == WAIT) begin
      go_resp_c = (cnt == '0);
    end
    in_range_c = (32'(acc_addr_c) < DEPTH);
  end

  // Request FSM, wait counter and registered completion flags.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= go_resp_c;
      err_q   <= go_resp_c && !in_range_c;
      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            addr_q  <= bus.addr_i;
            wr_q    <= bus.wr_rd_i;
            wdata_q <= bus.wdata_i;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - CNT_W'(1);
        end
        RESP:    state <= HOLD;
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sram_array #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_array (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .we      (go_resp_c && acc_wr_c && in_range_c),
    .re      (go_resp_c && !acc_wr_c),
    .rd_zero (!in_range_c),
    .addr    (acc_addr_c),
    .wdata   (acc_wdata_c),
    .rdata   (rdata)
  );

  assign bus.ready_o = ready_q;
  assign bus.err_o   = err_q;
  assign bus.rdata_o = rdata;

endmodule
